// File: rtl/johnson_monitor_if.sv
// Bundle between an upstream Johnson counter driver and johnson_monitor.
// The master drives the sampled code and the error clear; the slave
// (the monitor) drives the decoded phase, lock status, flags and counter.
interface johnson_monitor_if #(
  parameter int unsigned CNT_W = 8
);
  logic [3:0]       code_in;
  logic             code_valid;
  logic             clr_err;
  logic [2:0]       phase;
  logic             phase_valid;
  logic             locked;
  logic             seq_err;
  logic             illegal_err;
  logic [CNT_W-1:0] cycle_cnt;
  logic             cycle_pulse;

  modport master (
    output code_in, code_valid, clr_err,
    input  phase, phase_valid, locked, seq_err, illegal_err, cycle_cnt, cycle_pulse
  );

  modport slave (
    input  code_in, code_valid, clr_err,
    output phase, phase_valid, locked, seq_err, illegal_err, cycle_cnt, cycle_pulse
  );
endinterface

// File: rtl/johnson_monitor.sv
// Monitors a 4-bit Johnson counter: decodes each sampled code to a phase,
// locks after LOCK_N consecutive correct successors, flags illegal codes
// and out-of-order codes, and counts completed 8-phase cycles while locked.
// Every output is a flop updated from the sample taken on the same edge.
module johnson_monitor #(
  parameter int unsigned LOCK_N = 2,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  johnson_monitor_if.slave bus
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    LOCKED = 2'd1,
    FAULT  = 2'd2
  } state_t;

  // run_cnt value that, followed by one more successor, completes the lock run.
  localparam logic [3:0] LOCK_LAST = 4'(LOCK_N - 1);

  state_t           state, state_nxt;
  logic [3:0]       run_cnt, run_nxt;
  logic [2:0]       phase_q, phase_nxt;
  logic             phase_valid_q, phase_valid_nxt;
  logic             locked_q;
  logic             seq_err_q, seq_err_nxt;
  logic             illegal_err_q, illegal_err_nxt;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_nxt;
  logic             cycle_pulse_q, cycle_pulse_nxt;

  logic       is_legal;
  logic [2:0] dec_phase;
  logic       is_succ;
  logic       is_wrap;

  // Decode the incoming code against the eight legal Johnson patterns.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    is_legal  = 1'b1;
    dec_phase = 3'd0;
    unique case (bus.code_in)
      4'b1111: dec_phase = 3'd0;
      4'b0111: dec_phase = 3'd1;
      4'b0011: dec_phase = 3'd2;
      4'b0001: dec_phase = 3'd3;
      4'b0000: dec_phase = 3'd4;
      4'b1000: dec_phase = 3'd5;
      4'b1100: dec_phase = 3'd6;
      4'b1110: dec_phase = 3'd7;
      default: is_legal  = 1'b0;
    endcase
    // A successor needs a valid prior phase; a repeat never qualifies.
    is_succ = is_legal && phase_valid_q && (dec_phase == phase_q + 3'd1);
    is_wrap = is_succ && (dec_phase == 3'd0);
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples values from before the edge, independent of block order.
      state <= SEARCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; clr_err forces SEARCH from any state.
  always_comb begin
    state_nxt = state;
    if (bus.code_valid) begin
      unique case (state)
        SEARCH:  if (is_succ && run_cnt == LOCK_LAST) state_nxt = LOCKED;
        LOCKED:  if (!is_succ) state_nxt = FAULT;
        default: state_nxt = state;
      endcase
    end
    if (bus.clr_err) state_nxt = SEARCH;
  end

  // Next values of the datapath outputs; error sets are applied after the
  // clear so a same-edge error wins over clr_err.
  always_comb begin
    phase_nxt       = phase_q;
    phase_valid_nxt = phase_valid_q;
    run_nxt         = run_cnt;
    seq_err_nxt     = seq_err_q;
    illegal_err_nxt = illegal_err_q;
    cycle_cnt_nxt   = cycle_cnt_q;
    cycle_pulse_nxt = 1'b0;

    if (bus.clr_err) begin
      seq_err_nxt     = 1'b0;
      illegal_err_nxt = 1'b0;
      cycle_cnt_nxt   = '0;
      run_nxt         = 4'd0;
    end

    if (bus.code_valid) begin
      if (is_legal) begin
        phase_nxt       = dec_phase;
        phase_valid_nxt = 1'b1;
      end else begin
        phase_valid_nxt = 1'b0;
        illegal_err_nxt = 1'b1;
      end

      unique case (state)
        SEARCH: begin
          if (!bus.clr_err) begin
            run_nxt = (is_succ && run_cnt != LOCK_LAST) ? run_cnt + 4'd1 : 4'd0;
          end
        end
        LOCKED: begin
          if (is_wrap && !bus.clr_err) begin
            cycle_cnt_nxt   = cycle_cnt_q + CNT_W'(1);
            cycle_pulse_nxt = 1'b1;
          end else if (!is_succ && is_legal) begin
            seq_err_nxt = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_cnt       <= 4'd0;
      phase_q       <= 3'd0;
      phase_valid_q <= 1'b0;
      locked_q      <= 1'b0;
      seq_err_q     <= 1'b0;
      illegal_err_q <= 1'b0;
      cycle_cnt_q   <= '0;
      cycle_pulse_q <= 1'b0;
    end else begin
      run_cnt       <= run_nxt;
      phase_q       <= phase_nxt;
      phase_valid_q <= phase_valid_nxt;
      locked_q      <= (state_nxt == LOCKED);
      seq_err_q     <= seq_err_nxt;
      illegal_err_q <= illegal_err_nxt;
      cycle_cnt_q   <= cycle_cnt_nxt;
      cycle_pulse_q <= cycle_pulse_nxt;
    end
  end

  assign bus.phase       = phase_q;
  assign bus.phase_valid = phase_valid_q;
  assign bus.locked      = locked_q;
  assign bus.seq_err     = seq_err_q;
  assign bus.illegal_err = illegal_err_q;
  assign bus.cycle_cnt   = cycle_cnt_q;
  assign bus.cycle_pulse = cycle_pulse_q;

endmodule

// File: tb/tb_johnson_monitor.sv
// Self-checking bench for johnson_monitor: directed scenarios pinned with
// literal expectations, then randomized code streams, all compared every
// cycle against a behavioural model of the monitor's rules.
module tb_johnson_monitor;

  localparam int unsigned LOCK_N = 2;
  localparam int unsigned CNT_W  = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  johnson_monitor_if #(.CNT_W(CNT_W)) bus ();

  johnson_monitor #(.LOCK_N(LOCK_N), .CNT_W(CNT_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model state.
  bit m_locked, m_fault;
  int m_run, m_phase, m_cnt;
  bit m_pv, m_seq, m_ill, m_pulse;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Code for phase p: a 4-bit window sliding across eight ones then zeros.
  function automatic logic [3:0] code_of(input int p);
    logic [3:0] f;
    f = 4'hF;
    return (p < 4) ? (f >> p) : (f << (8 - p));
  endfunction

  function automatic int dec(input logic [3:0] c);
    for (int p = 0; p < 8; p++) if (code_of(p) == c) return p;
    return -1;
  endfunction

  task automatic model_reset();
    m_locked = 0; m_fault = 0; m_run = 0; m_phase = 0; m_cnt = 0;
    m_pv = 0; m_seq = 0; m_ill = 0; m_pulse = 0;
  endtask

  task automatic model_update(input logic [3:0] c, input logic v, input logic k);
    int  p;
    bit  legal, is_next;
    p       = dec(c);
    legal   = (p >= 0);
    is_next = legal && m_pv && (p == (m_phase + 1) % 8);
    m_pulse = 0;
    if (k) begin m_seq = 0; m_ill = 0; m_cnt = 0; end
    if (v) begin
      if (!legal) m_ill = 1;
      if (m_locked) begin
        if (is_next) begin
          if (p == 0 && !k) begin
            m_cnt   = (m_cnt + 1) % (1 << CNT_W);
            m_pulse = 1;
          end
        end else begin
          if (legal) m_seq = 1;
          m_locked = 0;
          m_fault  = 1;
        end
      end else if (!m_fault) begin
        m_run = is_next ? m_run + 1 : 0;
        if (m_run == int'(LOCK_N)) begin m_locked = 1; m_run = 0; end
      end
      if (legal) begin m_phase = p; m_pv = 1; end
      else m_pv = 0;
    end
    if (k) begin m_locked = 0; m_fault = 0; m_run = 0; end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("phase",       32'(bus.phase),       32'(m_phase));
      check("phase_valid", 32'(bus.phase_valid), 32'(m_pv));
      check("locked",      32'(bus.locked),      32'(m_locked));
      check("seq_err",     32'(bus.seq_err),     32'(m_seq));
      check("illegal_err", 32'(bus.illegal_err), 32'(m_ill));
      check("cycle_cnt",   32'(bus.cycle_cnt),   32'(m_cnt));
      check("cycle_pulse", 32'(bus.cycle_pulse), 32'(m_pulse));
    end
  end

  task automatic step(input logic [3:0] c, input logic v = 1'b1, input logic k = 1'b0);
    bus.code_in    = c;
    bus.code_valid = v;
    bus.clr_err    = k;
    @(posedge clk);
    #1;
    model_update(c, v, k);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_phase"},  32'(bus.phase),       32'd0);
    check({tag, "_pv"},     32'(bus.phase_valid), 32'd0);
    check({tag, "_locked"}, 32'(bus.locked),      32'd0);
    check({tag, "_seq"},    32'(bus.seq_err),     32'd0);
    check({tag, "_ill"},    32'(bus.illegal_err), 32'd0);
    check({tag, "_cnt"},    32'(bus.cycle_cnt),   32'd0);
    check({tag, "_pulse"},  32'(bus.cycle_pulse), 32'd0);
  endtask

  initial begin
    int g;
    bus.code_in    = 4'b0000;
    bus.code_valid = 1'b0;
    bus.clr_err    = 1'b0;
    model_reset();
    #12;
    check_reset_outputs("rst");
    @(negedge clk);
    rst = 1'b1;
    chk_en = 1'b1;

    // Lock on 1111, 0111, 0011.
    step(4'b1111); check("lk_ph0", 32'(bus.phase), 32'd0); check("lk_pv0", 32'(bus.phase_valid), 32'd1);
    step(4'b0111); check("lk_ph1", 32'(bus.phase), 32'd1); check("lk_l1", 32'(bus.locked), 32'd0);
    step(4'b0011); check("lk_ph2", 32'(bus.phase), 32'd2); check("lk_l2", 32'(bus.locked), 32'd1);

    // Locked at phase 3, then jump to 1100.
    step(4'b0001); check("sq_l3", 32'(bus.locked), 32'd1);
    step(4'b1100);
    check("sq_seq", 32'(bus.seq_err), 32'd1);
    check("sq_lk",  32'(bus.locked),  32'd0);
    check("sq_ph",  32'(bus.phase),   32'd6);
    step(4'b1110); step(4'b1111);
    check("flt_lk",  32'(bus.locked),    32'd0);
    check("flt_cnt", 32'(bus.cycle_cnt), 32'd0);

    // Clear, relock, then a first cycle completion.
    step(4'b0111, 1'b1, 1'b1); check("clr_seq", 32'(bus.seq_err), 32'd0);
    step(4'b0011); step(4'b0001); check("rl_lk", 32'(bus.locked), 32'd1);
    step(4'b0000); step(4'b1000); step(4'b1100); step(4'b1110);
    step(4'b1111);
    check("cyc_pulse1", 32'(bus.cycle_pulse), 32'd1);
    check("cyc_cnt1",   32'(bus.cycle_cnt),   32'd1);
    step(4'b0111);
    check("cyc_pulse0", 32'(bus.cycle_pulse), 32'd0);

    // 255 more completions wrap the 8-bit counter back to zero.
    for (int i = 0; i < 255 * 8; i++) step(code_of((2 + i) % 8));
    check("wrap_cnt", 32'(bus.cycle_cnt), 32'd0);
    check("wrap_lk",  32'(bus.locked),    32'd1);

    // code_valid low with toggling codes: everything holds.
    for (int i = 0; i < 5; i++) step(4'($urandom_range(15)), 1'b0);
    check("hold_ph", 32'(bus.phase),  32'd1);
    check("hold_lk", 32'(bus.locked), 32'd1);

    // Repeated code while locked.
    step(4'b0111);
    check("rep_seq", 32'(bus.seq_err), 32'd1);
    check("rep_lk",  32'(bus.locked),  32'd0);

    // Illegal code in SEARCH, then relock from scratch.
    step(4'b0011, 1'b1, 1'b1);
    step(4'b0101);
    check("ill_flag", 32'(bus.illegal_err), 32'd1);
    check("ill_pv",   32'(bus.phase_valid), 32'd0);
    step(4'b0001); step(4'b0000); check("ill_rl0", 32'(bus.locked), 32'd0);
    step(4'b1000); check("ill_rl1", 32'(bus.locked), 32'd1);

    // clr_err on the same edge as an illegal code while locked.
    step(4'b1100); step(4'b1110); step(4'b1111);
    check("pre_cnt", 32'(bus.cycle_cnt), 32'd1);
    step(4'b0101, 1'b1, 1'b1);
    check("ci_ill", 32'(bus.illegal_err), 32'd1);
    check("ci_seq", 32'(bus.seq_err),     32'd0);
    check("ci_cnt", 32'(bus.cycle_cnt),   32'd0);
    check("ci_lk",  32'(bus.locked),      32'd0);

    // Relock, then an asynchronous reset pulse mid-cycle.
    step(4'b0111); step(4'b0011); step(4'b0001);
    check("prer_lk", 32'(bus.locked), 32'd1);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("arst");
    @(negedge clk);
    #2 rst = 1'b1;

    // Randomized streams, mostly well-behaved with occasional faults.
    g = 0;
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [3:0] c;
      logic v, k;
      r = int'($urandom_range(99));
      if (r < 80)      begin g = (g + 1) % 8; c = code_of(g); end
      else if (r < 88) c = code_of(g);
      else if (r < 94) begin g = int'($urandom_range(7)); c = code_of(g); end
      else             c = 4'($urandom_range(15));
      v = ($urandom_range(99) < 90);
      k = v && ($urandom_range(99) < 3);
      step(c, v, k);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
